// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = A - B - Bin, one bit per clock, LSB first.
// Reports final borrow (Bout) and signed two's-complement Overflow on completion.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             Bout,
    output logic             Overflow
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             a_bit, b_bit, d_bit, br_next;
    logic [WIDTH-1:0] res_shifted;

    // Full-subtractor cell on the bit selected by the counter.
    always_comb begin
        a_bit       = a_q[cnt_q];
        b_bit       = b_q[cnt_q];
        d_bit       = a_bit ^ b_bit ^ br_q;
        br_next     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
        res_shifted = {d_bit, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                res_d = res_shifted;
                br_d  = br_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    state_d = StDone;
                    diff_d  = res_shifted;
                    bout_d  = br_next;
                    // Operands of differing sign whose result sign differs from A.
                    ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d_bit ^ a_q[WIDTH-1]);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign diff     = diff_q;
    assign Bout     = bout_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed and random 8-bit operations plus an
// exhaustive 4-bit sweep, checked against an arithmetic reference model.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n8, rst_n4;
    logic       start8, start4;
    logic [7:0] a8, b8, diff8;
    logic [3:0] a4, b4, diff4;
    logic       bin8, bin4;
    logic       busy8, done8, bout8, ovf8;
    logic       busy4, done4, bout4, ovf4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n8),
        .start    (start8),
        .A        (a8),
        .B        (b8),
        .Bin      (bin8),
        .busy     (busy8),
        .done     (done8),
        .diff     (diff8),
        .Bout     (bout8),
        .Overflow (ovf8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n4),
        .start    (start4),
        .A        (a4),
        .B        (b4),
        .Bin      (bin4),
        .busy     (busy4),
        .done     (done4),
        .diff     (diff4),
        .Bout     (bout4),
        .Overflow (ovf4)
    );

    // Returns {Overflow, Bout, diff} for a w-bit subtraction a - b - bin.
    function automatic int ref_sub(input int w, input int a, input int b, input int bin);
        int half, r, sa, sb, sr, bo, ov;
        half = 1 << (w - 1);
        r    = a - b - bin;
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        sr   = sa - sb - bin;
        bo   = (r < 0) ? 1 : 0;
        ov   = (sr < -half || sr >= half) ? 1 : 0;
        return (r & (2 * half - 1)) | (bo << w) | (ov << (w + 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        a8     = a;
        b8     = b;
        bin8   = bin;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    // Waits for done, checking latency, busy cycles, result hold and final result.
    task automatic wait8(input string tag, input int remaining, input logic [7:0] hold,
                         input int exp);
        int   n    = 0;
        int   nb   = 0;
        logic held = 1'b1;
        while (done8 !== 1'b1 && n < 20) begin
            if (busy8 === 1'b1) nb++;
            if (diff8 !== hold) held = 1'b0;
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, remaining);
        chk({tag, "_busy_cycles"}, nb, remaining);
        chk({tag, "_hold"}, {31'd0, held}, 1);
        chk({tag, "_result"}, {22'd0, ovf8, bout8, diff8}, exp);
        chk({tag, "_busy_in_done"}, {31'd0, busy8}, 0);
    endtask

    initial begin
        int dn, nb, n, exp;
        logic [7:0] ra, rb, last;
        logic       rbin;

        rst_n8 = 1'b0;
        rst_n4 = 1'b0;
        start8 = 1'b0;
        start4 = 1'b0;
        a8 = '0; b8 = '0; bin8 = 1'b0;
        a4 = '0; b4 = '0; bin4 = 1'b0;
        #12;
        chk("reset_state8", {busy8, done8, ovf8, bout8, diff8}, 0);
        chk("reset_state4", {busy4, done4, ovf4, bout4, diff4}, 0);
        tick();
        rst_n8 = 1'b1;
        rst_n4 = 1'b1;

        // 1: basic subtraction, latency and one-cycle done pulse
        launch8(8'd100, 8'd37, 1'b0);
        chk("t1_busy_after_accept", {31'd0, busy8}, 1);
        wait8("t1", 8, 8'h00, ref_sub(8, 100, 37, 0));
        chk("t1_result_abs", {22'd0, ovf8, bout8, diff8}, {22'd0, 2'b00, 8'h3F});
        tick();
        chk("t1_done_pulse", {31'd0, done8}, 0);

        // 2: borrow out, and full borrow-in with equal operands
        launch8(8'h05, 8'h0A, 1'b0);
        wait8("t2a", 8, 8'h3F, ref_sub(8, 5, 10, 0));
        tick();
        launch8(8'h00, 8'h00, 1'b1);
        wait8("t2b", 8, 8'hFB, ref_sub(8, 0, 0, 1));
        chk("t2b_abs", {22'd0, ovf8, bout8, diff8}, {22'd0, 2'b01, 8'hFF});
        tick();

        // 3: signed overflow both directions
        launch8(8'h80, 8'h01, 1'b0);
        wait8("t3a", 8, 8'hFF, ref_sub(8, 8'h80, 1, 0));
        chk("t3a_abs", {22'd0, ovf8, bout8, diff8}, {22'd0, 2'b10, 8'h7F});
        tick();
        launch8(8'h7F, 8'hFF, 1'b0);
        wait8("t3b", 8, 8'h7F, ref_sub(8, 8'h7F, 8'hFF, 0));
        chk("t3b_abs", {22'd0, ovf8, bout8, diff8}, {22'd0, 2'b11, 8'h80});
        tick();

        // 4: start during RUN ignored; start in DONE accepted back-to-back
        launch8(8'h50, 8'h10, 1'b0);
        tick();
        tick();
        launch8(8'h01, 8'h02, 1'b0);
        a8 = 8'hAA;
        b8 = 8'h55;
        wait8("t4a", 5, 8'h80, ref_sub(8, 8'h50, 8'h10, 0));
        launch8(8'h10, 8'h20, 1'b0);
        wait8("t4b", 8, 8'h40, ref_sub(8, 8'h10, 8'h20, 0));
        chk("t4b_abs", {22'd0, ovf8, bout8, diff8}, {22'd0, 2'b01, 8'hF0});
        tick();

        // 5: asynchronous reset mid-RUN aborts without a done pulse
        launch8(8'h33, 8'h11, 1'b0);
        tick();
        tick();
        tick();
        rst_n8 = 1'b0;
        #1;
        chk("t5_async_clear", {busy8, done8, ovf8, bout8, diff8}, 0);
        tick();
        rst_n8 = 1'b1;
        dn = 0;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 === 1'b1) dn++;
            if (busy8 === 1'b1) nb++;
            tick();
        end
        chk("t5_no_done", dn, 0);
        chk("t5_no_busy", nb, 0);
        launch8(8'h33, 8'h11, 1'b0);
        wait8("t5", 8, 8'h00, ref_sub(8, 8'h33, 8'h11, 0));
        tick();

        // Random operations, some with inputs wiggled during RUN
        last = diff8;
        for (int k = 0; k < 24; k++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            launch8(ra, rb, rbin);
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            bin8 = 1'($urandom);
            exp  = ref_sub(8, ra, rb, rbin);
            wait8("rand8", 8, last, exp);
            last = 8'(exp);
            if ($urandom_range(0, 1) == 1) tick();
        end

        // 6: exhaustive 4-bit sweep with back-to-back starts
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    a4     = 4'(a);
                    b4     = 4'(b);
                    bin4   = 1'(c);
                    start4 = 1'b1;
                    tick();
                    start4 = 1'b0;
                    n = 0;
                    while (done4 !== 1'b1 && n < 10) begin
                        tick();
                        n++;
                    end
                    chk($sformatf("exh4_a%0d_b%0d_c%0d", a, b, c),
                        {n[25:0], ovf4, bout4, diff4},
                        {26'd4, 6'(ref_sub(4, a, b, c))});
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
